// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the asynchronous FIFO (rclk domain).
// A start pulse pops burst_len words from the FIFO read port and forwards
// them on a valid/ready stream through a 2-entry registered buffer.
//
// Ports:
//   rclk, rrst          clock, synchronous active-high reset
//   rinc, rempty, rdata FIFO read port (rdata FWFT when RD_LAT=0,
//                       one cycle after rinc when RD_LAT=1)
//   start, burst_len    burst command; burst_len sampled when start is taken
//   busy, done          burst in progress / one-cycle completion pulse
//   m_valid, m_data,
//   m_ready             output stream
//   rd_count            total FIFO pops since reset (wraps)
module fifo_rd_stream #(
    parameter int DSIZE  = 8,
    parameter int CNT_W  = 8,
    parameter int RD_LAT = 0
) (
    input  logic             rclk,
    input  logic             rrst,
    output logic             rinc,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len, issued;
    logic [1:0]       occ, occ_nxt;
    logic             inflight, inflight_nxt;
    logic [DSIZE-1:0] mem [2];
    logic             rptr, wptr;
    logic             pop, push;
    logic [2:0]       fill;

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = mem[rptr];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Slots committed after this edge: buffered + outstanding read - word leaving.
    assign fill = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Registered-read FIFOs deliver the word one cycle after rinc.
    assign push         = (RD_LAT == 0) ? rinc : inflight;
    assign inflight_nxt = (RD_LAT == 0) ? 1'b0 : rinc;

    always_comb begin
        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = occ + 2'd1;
        else if (!push && pop)
            occ_nxt = occ - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        rinc      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (burst_len != '0) ? RUN : DONE;
            end
            RUN: begin
                rinc = !rempty && (issued < len) && (fill < 3'd2);
                if (rinc && (issued == len - CNT_ONE))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (occ_nxt == 2'd0 && !inflight_nxt && !inflight)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state    <= IDLE;
            len      <= '0;
            issued   <= '0;
            rd_count <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            rptr     <= 1'b0;
            wptr     <= 1'b0;
            for (int unsigned i = 0; i < 2; i++)
                mem[i] <= '0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            inflight <= inflight_nxt;
            if (state == IDLE && start) begin
                len    <= burst_len;
                issued <= '0;
            end
            if (rinc) begin
                issued   <= issued + CNT_ONE;
                rd_count <= rd_count + CNT_ONE;
            end
            if (push) begin
                mem[wptr] <= rdata;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: runs an RD_LAT=0 and an RD_LAT=1 instance side by side
// on shared command/stream stimulus. Each instance reads its own copy of an
// endless FIFO word stream; the model expects the output to be that stream,
// in order, contiguous from the last reset, with per-burst completion rules.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rrst, start, m_ready, rempty;
    logic [7:0] burst_len;
    logic       rinc_s [2];
    logic       busy_s [2];
    logic       done_s [2];
    logic       mv_s   [2];
    logic [7:0] rdata_s[2];
    logic [7:0] md_s   [2];
    logic [7:0] rdc_s  [2];

    always #5 clk = ~clk;

    fifo_rd_stream #(.DSIZE(8), .CNT_W(8), .RD_LAT(0)) dut0 (
        .rclk(clk), .rrst(rrst), .rinc(rinc_s[0]), .rempty(rempty),
        .rdata(rdata_s[0]), .start(start), .burst_len(burst_len),
        .busy(busy_s[0]), .done(done_s[0]), .m_valid(mv_s[0]),
        .m_data(md_s[0]), .m_ready(m_ready), .rd_count(rdc_s[0])
    );

    fifo_rd_stream #(.DSIZE(8), .CNT_W(8), .RD_LAT(1)) dut1 (
        .rclk(clk), .rrst(rrst), .rinc(rinc_s[1]), .rempty(rempty),
        .rdata(rdata_s[1]), .start(start), .burst_len(burst_len),
        .busy(busy_s[1]), .done(done_s[1]), .m_valid(mv_s[1]),
        .m_data(md_s[1]), .m_ready(m_ready), .rd_count(rdc_s[1])
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  src [4096];
    int unsigned idx      [2];
    int unsigned exp_ptr  [2];
    int unsigned cyc = 0;
    bit          active   [2];
    bit          post_rst [2];
    bit          hold_v   [2];
    bit          clean    [2];
    bit          pend_pop [2];
    logic [7:0]  hold_d   [2];
    int unsigned cur_len  [2];
    int unsigned start_cyc[2];
    int unsigned delivered[2];
    int unsigned pops     [2];
    logic [7:0]  sum_len  [2];

    task automatic chk(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h", tag, k, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] word(input int unsigned i);
        return src[i % 4096];
    endfunction

    // Evaluate instance k just before the coming posedge.
    task automatic eval(input int k);
        bit pop_f, acc, was_active;
        pop_f = (rinc_s[k] === 1'b1) && !rempty;
        pend_pop[k] = pop_f;
        if (rrst) begin
            active[k]    = 1'b0;
            post_rst[k]  = 1'b1;
            hold_v[k]    = 1'b0;
            exp_ptr[k]   = idx[k] + (pop_f ? 1 : 0);
            delivered[k] = 0;
            pops[k]      = 0;
            sum_len[k]   = 8'd0;
            return;
        end
        if (post_rst[k]) begin
            chk("rst_mvalid", k, 32'(mv_s[k]), 0);
            chk("rst_busy",   k, 32'(busy_s[k]), 0);
            chk("rst_rinc",   k, 32'(rinc_s[k]), 0);
            chk("rst_done",   k, 32'(done_s[k]), 0);
            chk("rst_rdcnt",  k, 32'(rdc_s[k]), 0);
            chk("rst_mdata",  k, 32'(md_s[k]), 0);
            post_rst[k] = 1'b0;
        end
        if (rempty) chk("rinc_empty", k, 32'(rinc_s[k]), 0);
        if (!active[k]) chk("rinc_idle", k, 32'(rinc_s[k]), 0);
        if (hold_v[k]) begin
            chk("hold_valid", k, 32'(mv_s[k]), 1);
            chk("hold_data",  k, 32'(md_s[k]), 32'(hold_d[k]));
        end
        chk("busy", k, 32'(busy_s[k]), 32'(active[k]));
        acc = (mv_s[k] === 1'b1) && m_ready;
        if (acc) begin
            chk("data",   k, 32'(md_s[k]), 32'(word(exp_ptr[k])));
            chk("popped", k, 32'(exp_ptr[k] < idx[k]), 1);
            exp_ptr[k]++;
            delivered[k]++;
        end
        if (pop_f) begin
            pops[k]++;
            chk("overpop", k, 32'(pops[k] <= cur_len[k]), 1);
        end
        if (active[k] && done_s[k] !== 1'b1 && (!m_ready || rempty))
            clean[k] = 1'b0;
        was_active = active[k];
        if (done_s[k] === 1'b1) begin
            chk("done_active", k, 32'(active[k]), 1);
            chk("done_count",  k, delivered[k], cur_len[k]);
            chk("done_rdcnt",  k, 32'(rdc_s[k]), 32'(sum_len[k]));
            if (clean[k])
                chk("done_lat", k, cyc - start_cyc[k],
                    (cur_len[k] == 0) ? 1 : cur_len[k] + 2 + k);
            active[k] = 1'b0;
        end
        if (start && !was_active) begin
            active[k]    = 1'b1;
            cur_len[k]   = burst_len;
            start_cyc[k] = cyc;
            clean[k]     = 1'b1;
            delivered[k] = 0;
            pops[k]      = 0;
            sum_len[k]   = sum_len[k] + burst_len;
        end
        hold_v[k] = (mv_s[k] === 1'b1) && !m_ready;
        hold_d[k] = md_s[k];
    endtask

    // One clock: evaluate, take the edge, then advance the FIFO models.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) eval(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++)
            if (pend_pop[k]) idx[k]++;
        rdata_s[0] = word(idx[0]);
        rdata_s[1] = pend_pop[1] ? word(idx[1] - 1) : 8'($urandom);
    endtask

    task automatic pulse_start(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
        burst_len = 8'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!active[0] && !active[1]) break;
            tick();
        end
        tick();
        chk("idle_busy", 0, {30'b0, busy_s[1], busy_s[0]}, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) src[i] = 8'($urandom);
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        for (int k = 0; k < 2; k++) begin
            idx[k] = 0; exp_ptr[k] = 0; active[k] = 0; post_rst[k] = 0;
            hold_v[k] = 0; clean[k] = 0; pend_pop[k] = 0; hold_d[k] = 0;
            cur_len[k] = 0; start_cyc[k] = 0; delivered[k] = 0; pops[k] = 0;
            sum_len[k] = 0;
        end
        rrst = 1'b1; start = 1'b0; m_ready = 1'b1; rempty = 1'b0;
        burst_len = 8'd0;
        rdata_s[0] = src[0]; rdata_s[1] = 8'h00;
        @(posedge clk); #1;
        tick(); tick();
        rrst = 1'b0;
        tick();

        // Preloaded 11,22,33,44 streamed at full rate on both latencies.
        pulse_start(8'd4);
        wait_idle(30);

        // Backpressure: only two pops fit before the stream stalls.
        m_ready = 1'b0;
        pulse_start(8'd5);
        for (int i = 0; i < 5; i++) tick();
        for (int k = 0; k < 2; k++) chk("bp_pops", k, pops[k], 2);
        m_ready = 1'b1;
        wait_idle(40);

        // FIFO runs dry for three cycles mid-burst.
        pulse_start(8'd6);
        tick(); tick();
        rempty = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        for (int k = 0; k < 2; k++) chk("stall_busy", k, 32'(busy_s[k]), 1);
        rempty = 1'b0;
        wait_idle(40);

        // Zero-length burst, then a start pulse ignored while busy.
        pulse_start(8'd0);
        wait_idle(10);
        pulse_start(8'd3);
        tick();
        pulse_start(8'd7);
        wait_idle(40);

        // Reset while the buffer holds two words.
        m_ready = 1'b0;
        pulse_start(8'd8);
        for (int i = 0; i < 5; i++) tick();
        for (int k = 0; k < 2; k++) chk("pre_rst_valid", k, 32'(mv_s[k]), 1);
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        m_ready = 1'b1;
        tick();
        wait_idle(10);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            m_ready   = ($urandom % 4) != 0;
            rempty    = ($urandom % 5) == 0;
            start     = ($urandom % 6) == 0;
            burst_len = 8'($urandom % 12);
            rrst      = ($urandom % 400) == 0;
            tick();
        end
        rrst = 1'b0; start = 1'b0; m_ready = 1'b1; rempty = 1'b0;
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO. Sits in the rclk domain and is the counterpart to the write-side producer.
- On a start command it pops a programmed number of words from the FIFO read port (rinc/rempty/rdata) and forwards them on a valid/ready output stream through a 2-entry buffer.
- Supports both first-word-fall-through and registered FIFO read data.
- Signals done when the last word has been accepted downstream.

Parameters:
DSIZE, 8, FIFO data width in bits.
CNT_W, 8, width of burst length and counters.
RD_LAT, 0, FIFO read latency: 0 = rdata valid in the rinc cycle (FWFT); 1 = rdata valid the cycle after rinc.

Ports:
rclk  input  1  read-domain clock; all logic on posedge.
rrst  input  1  synchronous active-high reset.
rinc  output  1  FIFO pop request.
rempty  input  1  FIFO empty flag (already synchronized to rclk).
rdata  input  DSIZE  FIFO read data.
start  input  1  one-cycle pulse; begins a burst.
burst_len  input  CNT_W  words to read; sampled when start is accepted.
busy  output  1  high from start acceptance until the done cycle, inclusive.
done  output  1  one-cycle pulse when the burst completes.
m_valid  output  1  output stream valid.
m_data  output  DSIZE  output stream data.
m_ready  input  1  output stream ready.
rd_count  output  CNT_W  total FIFO pops since reset; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst is synchronous and active-high. While rrst=1 at a posedge, state goes to IDLE and buffer, counters and any in-flight read are cleared.
- Reset values: rinc=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0.
- Reset mid-burst: burst aborted, buffered and in-flight data discarded, no done pulse.
- States:
  - IDLE:
    - start=1 latches len=burst_len and clears issued.
    - If len!=0: next state RUN, busy=1.
    - If len==0: next state DONE.
  - RUN:
    - rinc = !rempty && (issued<len) && (occ + inflight - pop < 2), where pop = m_valid && m_ready.
    - Each rinc increments issued and rd_count.
    - When issued reaches len (after the final rinc): next state DRAIN.
  - DRAIN: rinc=0. When occ==0 and inflight==0 after this edge's pop: next state DONE.
  - DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- start while not in IDLE is ignored. start in the DONE cycle is also ignored.
- rinc is combinational from state, rempty, occ, inflight and m_ready. The path m_ready->rinc exists by design.
- Capture:
  - RD_LAT=0: rdata is written into the buffer in the same cycle rinc=1.
  - RD_LAT=1: inflight is set on rinc, and rdata is written into the buffer on the following cycle.
- Buffer:
  - 2-entry FIFO with occupancy occ in 0..2.
  - m_valid = (occ!=0); m_data = head entry, registered storage, no combinational path from rdata.
  - Push and pop in the same cycle: occ is unchanged and order is preserved.
  - Overflow is impossible by the rinc rule. m_data holds its value while m_valid=1 and m_ready=0.
- Throughput: with m_ready held 1 and the FIFO non-empty, one word per cycle is sustained for both RD_LAT values.
- rinc is never asserted while rempty=1. The rempty=1 cycle simply stalls with no underflow.
- m_valid must not drop without a pop.

Test Plan:
1. FIFO preloaded with 0x11,0x22,0x33,0x44; burst_len=4; m_ready=1 -> four consecutive rinc cycles. m_data sequence 11,22,33,44 on consecutive cycles (RD_LAT=0); done pulses one cycle after the last accept; rd_count=4.
2. Same as 1 with RD_LAT=1 -> identical m_data order; first m_valid one cycle later than in scenario 1; still 1 word/cycle.
3. Backpressure: burst_len=5, m_ready=0 for 6 cycles, then 1 -> exactly 2 pops before stall; m_data=first word held stable while stalled; all 5 delivered in order.
4. Empty stall: FIFO empty for 3 cycles mid-burst -> rinc=0 throughout the stall; busy stays 1; burst resumes and completes when data arrives.
5. burst_len=0 start -> no rinc; done=1 on the following cycle; rd_count unchanged. start pulsed again while busy in a normal burst -> ignored.
6. rrst asserted mid-burst with occ=2 -> next cycle m_valid=0, busy=0, rinc=0, rd_count=0; no done pulse.
